imem_fetch_sequencer: RTL and testbench

Sequences the word-addressed, combinational-read instruction memory for the single-cycle/pipelined MIPS core. Owns the PC and issues one fetch address per cycle. Buffers fetched {pc, instruction} pairs in a 2-entry queue toward decode using a valid/ready handshake. Handles redirects (branch/jump) and stops fetching after a syscall until it is redirected.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_skid_queue.sv | 67 ++++++
 rtl/imem_fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_imem_fetch_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Shared by the top level (imem_fetch_sequencer) and the fetch_skid_queue sub-module.
package fetch_pkg;

    // Fetch control states: fetching, draining after a syscall, halted.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Default instruction word that stops fetching (MIPS syscall).
    localparam logic [31:0] DEF_SYSCALL_WORD = 32'h0000_000C;

    // Default PC loaded on reset.
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    // Mask that clears the byte offset of a PC.
    localparam logic [31:0] PC_WORD_MASK = 32'hFFFF_FFFC;

    // One queued fetch result: byte PC and the instruction word fetched there.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_queue.sv
// Two-entry fetch queue (skid buffer) with push, pop and flush.
// The head entry is presented directly from storage, so an entry pushed into
// an empty queue is visible at the output on the next cycle.
// Push and pop in the same cycle on a full queue are legal. The freed head
// slot is rewritten, and the count stays at 2.
module fetch_skid_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  fetch_entry_t i_push_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    output fetch_entry_t o_head_entry,
    output logic [1:0]   o_count
);

    fetch_entry_t r_mem [2];
    logic         r_head;
    logic [1:0]   r_count;

    logic         w_empty;
    logic         w_full;
    logic         w_do_pop;
    logic         w_do_push;
    logic         w_tail;

    assign w_empty   = (r_count == 2'd0);
    assign w_full    = (r_count == 2'd2);
    // A flush cancels any pop or push issued in the same cycle.
    assign w_do_pop  = i_pop && !w_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);
    // The tail slot is (head + count) mod 2. When the queue is full, this is
    // the head slot, which is being popped in the same cycle.
    assign w_tail    = r_head ^ r_count[0];

    assign o_head_entry = r_mem[r_head];
    assign o_count      = r_count;

    // Storage, head pointer and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[w_tail] <= i_push_entry;
            end
            if (i_flush) begin
                r_count <= 2'd0;
            end else begin
                if (w_do_pop) begin
                    r_head <= ~r_head;
                end
                case ({w_do_push, w_do_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer for a combinational-read instruction memory.
// This block owns the PC and fetches one word per cycle into a 2-entry queue
// toward decode. A redirect flushes the queue and restarts the PC at the new
// target. After a syscall word is fetched, fetching stops until the next redirect.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetched, perf_stall
// and perf_flush counters.
//
// Decode handshake: an entry transfers on a cycle with out_valid && out_ready.
// out_valid depends only on registered queue state and never on out_ready.
// out_pc and out_instr hold steady while out_valid is high and no transfer occurs.
module imem_fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEF_RESET_PC,
    parameter logic [31:0] SYSCALL_WORD = DEF_SYSCALL_WORD,
    // Queue depth. Only a depth of 2 is supported.
    parameter int          QDEPTH       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
`endif
    output logic        halted
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_WORD_MASK;
    localparam logic [1:0]  QCOUNT_FULL      = 2'(QDEPTH);

    fetch_state_t r_state;
    logic [31:0]  r_pc;

    fetch_entry_t w_push_entry;
    fetch_entry_t w_head_entry;
    logic [1:0]   w_q_count;
    logic         w_q_valid;
    logic         w_pop;
    logic         w_push;
    logic [31:0]  w_redirect_target;

    assign w_q_valid         = (w_q_count != 2'd0);
    assign w_pop             = w_q_valid && out_ready;
    // Fetch only while running and enabled, and never in a redirect cycle.
    // A full queue accepts a new word only if its head leaves this cycle.
    assign w_push            = (r_state == RUN) && fetch_en && !redirect_valid &&
                               ((w_q_count != QCOUNT_FULL) || w_pop);
    assign w_redirect_target = redirect_pc & PC_WORD_MASK;

    assign w_push_entry.pc    = r_pc;
    assign w_push_entry.instr = imem_instr;

    assign imem_addr = r_pc;
    assign out_valid = w_q_valid;
    assign out_pc    = w_head_entry.pc;
    assign out_instr = w_head_entry.instr;
    // The queue is always empty in HALT (no pushes), but both terms are kept
    // so the output matches its definition directly.
    assign halted    = (r_state == HALT) && !w_q_valid;

    fetch_skid_queue u_queue (
        .clk          (clk),
        .reset        (reset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .o_head_entry (w_head_entry),
        .o_count      (w_q_count)
    );

    // PC and fetch-state FSM. A redirect overrides everything except reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_pc    <= RESET_PC_ALIGNED;
        end else if (redirect_valid) begin
            r_state <= RUN;
            r_pc    <= w_redirect_target;
        end else begin
            if (w_push) begin
                r_pc <= r_pc + 32'd4;
            end
            case (r_state)
                RUN: begin
                    if (w_push && (imem_instr == SYSCALL_WORD)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!w_q_valid) begin
                        r_state <= HALT;
                    end
                end
                HALT: begin
                    r_state <= HALT;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic        w_stall;

    assign w_stall = (r_state == RUN) && fetch_en && !redirect_valid && !w_push;

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
    assign perf_flush   = r_perf_flush;

    // Free-running event counters that wrap at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_fetched <= 32'd0;
            r_perf_stall   <= 32'd0;
            r_perf_flush   <= 32'd0;
        end else begin
            if (w_push) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (redirect_valid && w_q_valid) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed testbench for imem_fetch_sequencer.
// The bench models instruction memory so that each word encodes its own address
// (low 12 bits). The syscall word is placed at 0x80.
// Outputs are sampled on the falling clock edge. Inputs change right after sampling.
module tb_imem_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    logic [31:0] imem [0:1023];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_instr = imem[imem_addr[11:2]];

    imem_fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_flush     (perf_flush),
`endif
        .halted         (halted)
    );

    // Memory model: each word holds its address, and the word at 0x80 is a syscall.
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [11:0] lo;
        lo = a[11:0];
        if (lo == 12'h080) return 32'h0000_000C;
        return 32'h1000_0000 | {20'h0, lo};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        fetch_en = 1'b1; out_ready = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        fetch_en = 1'b1; out_ready = 1'b1;
        tick; tick;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_out_pc got=%h want=0", out_pc); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr got=%h want=0", out_instr); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b want=0", halted); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_imem_addr got=%h want=0", imem_addr); end
        redirect_valid = 1'b0;
        reset = 1'b0;
    endtask

    // Stream 0x00..0x80 with out_ready=1, then drain and halt on the syscall.
    task automatic test_stream;
        logic [31:0] e;
        int gaps;
        bit done;
        e = 32'h0; gaps = 0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            tick;
            if (out_valid === 1'b1) begin
                total++;
                if (out_pc !== e || out_instr !== exp_word(e)) begin
                    bad++; $display("FAIL stream_item got=%h/%h want=%h/%h", out_pc, out_instr, e, exp_word(e));
                end
                if (e == 32'h80) done = 1'b1;
                e = e + 32'd4;
            end else if (e != 32'h0) begin
                gaps++;
            end
        end
        total++; if (!done) begin bad++; $display("FAIL stream_timeout got=%h want=84", e); end
        total++; if (gaps != 0) begin bad++; $display("FAIL stream_gaps got=%0d want=0", gaps); end
        tick;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL drain_halted got=%0b want=0", halted); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_out_valid got=%0b want=0", out_valid); end
        tick;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_halted got=%0b want=1", halted); end
        total++; if (imem_addr !== 32'h84) begin bad++; $display("FAIL halt_imem_addr got=%h want=84", imem_addr); end
        tick; tick; tick;
        total++; if (halted !== 1'b1 || imem_addr !== 32'h84 || out_valid !== 1'b0) begin
            bad++; $display("FAIL halt_hold got=%0b/%h/%0b want=1/84/0", halted, imem_addr, out_valid);
        end
    endtask

    // From HALT, a redirect to 0x10 resumes fetching.
    task automatic test_halt_redirect;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0010;
        tick;
        redirect_valid = 1'b0;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL hredir_halted got=%0b want=0", halted); end
        total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL hredir_imem_addr got=%h want=10", imem_addr); end
        tick;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== exp_word(32'h10)) begin
            bad++; $display("FAIL hredir_first got=%0b/%h/%h want=1/10/%h", out_valid, out_pc, out_instr, exp_word(32'h10));
        end
        tick;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h14) begin
            bad++; $display("FAIL hredir_second got=%0b/%h want=1/14", out_valid, out_pc);
        end
    endtask

    // Hold out_ready low: the queue fills, the PC stalls, then entries drain in order.
    task automatic test_backpressure;
        do_reset;
        for (int i = 0; i < 6; i++) tick;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            bad++; $display("FAIL bp_head got=%0b/%h want=1/0", out_valid, out_pc);
        end
        total++; if (imem_addr !== 32'h08) begin bad++; $display("FAIL bp_imem_addr got=%h want=8", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_fetched !== 32'd2) begin bad++; $display("FAIL bp_perf_fetched got=%0d want=2", perf_fetched); end
        total++; if (perf_stall !== 32'd4) begin bad++; $display("FAIL bp_perf_stall got=%0d want=4", perf_stall); end
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * i) || out_instr !== exp_word(32'(4 * i))) begin
                bad++; $display("FAIL bp_release[%0d] got=%0b/%h want=1/%h", i, out_valid, out_pc, 32'(4 * i));
            end
            tick;
        end
    endtask

    // Redirect on a full queue while decode is accepting: old entries vanish.
    task automatic test_redirect_full;
        do_reset;
        tick; tick; tick;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0043; out_ready = 1'b1;
        tick;
        redirect_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%0b want=0", out_valid); end
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL redir_imem_addr got=%h want=40", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (perf_flush !== 32'd1) begin bad++; $display("FAIL redir_perf_flush got=%0d want=1", perf_flush); end
`endif
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'(32'h40 + 4 * i)) begin
                bad++; $display("FAIL redir_seq[%0d] got=%0b/%h want=1/%h", i, out_valid, out_pc, 32'(32'h40 + 4 * i));
            end
        end
    endtask

    // Redirect to the top of the address space. The target offset bits are dropped, and the PC wraps to 0.
    task automatic test_wrap;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; out_ready = 1'b1;
        tick;
        redirect_valid = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_target got=%h want=fffffffc", imem_addr); end
        tick;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_instr !== 32'h1000_0FFC) begin
            bad++; $display("FAIL wrap_top got=%0b/%h/%h want=1/fffffffc/10000ffc", out_valid, out_pc, out_instr);
        end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h want=0", imem_addr); end
        tick;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            bad++; $display("FAIL wrap_zero got=%0b/%h want=1/0", out_valid, out_pc);
        end
    endtask

    // With fetch_en low, the queue drains and the PC holds. Fetching resumes from the held PC.
    task automatic test_fetch_en;
        do_reset;
        out_ready = 1'b1;
        tick; tick; tick;
        total++; if (out_pc !== 32'h08 || imem_addr !== 32'h0C) begin
            bad++; $display("FAIL fen_pre got=%h/%h want=8/c", out_pc, imem_addr);
        end
        fetch_en = 1'b0;
        tick;
        total++; if (out_valid !== 1'b0 || imem_addr !== 32'h0C) begin
            bad++; $display("FAIL fen_drain got=%0b/%h want=0/c", out_valid, imem_addr);
        end
        tick; tick;
        total++; if (out_valid !== 1'b0 || imem_addr !== 32'h0C) begin
            bad++; $display("FAIL fen_hold got=%0b/%h want=0/c", out_valid, imem_addr);
        end
        fetch_en = 1'b1;
        tick;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0C) begin
            bad++; $display("FAIL fen_resume got=%0b/%h want=1/c", out_valid, out_pc);
        end
        tick;
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h10) begin
            bad++; $display("FAIL fen_next got=%0b/%h want=1/10", out_valid, out_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = exp_word(32'(i * 4));
        reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);
        test_reset;
        test_stream;
        test_halt_redirect;
        test_backpressure;
        test_redirect_full;
        test_wrap;
        test_fetch_en;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Time limit so the run always ends.
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
